// File: rtl/rv_iommu_reg_widener.sv
// Bridges 32-bit register accesses to a 64-bit register map as strobed doubleword accesses.
// Keeps a low/high read snapshot for coherent 64-bit reads, and aborts hung downstream accesses.
module rv_iommu_reg_widener #(
  parameter int ADDR_WIDTH = 32,
  parameter int SNAP_EN    = 1,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  up_valid_i,
  input  logic                  up_write_i,
  input  logic [ADDR_WIDTH-1:0] up_addr_i,
  input  logic [31:0]           up_wdata_i,
  input  logic [3:0]            up_wstrb_i,
  output logic                  up_ready_o,
  output logic [31:0]           up_rdata_o,
  output logic                  up_error_o,
  output logic                  dn_valid_o,
  output logic                  dn_write_o,
  output logic [ADDR_WIDTH-1:0] dn_addr_o,
  output logic [63:0]           dn_wdata_o,
  output logic [7:0]            dn_wstrb_o,
  input  logic                  dn_ready_i,
  input  logic [63:0]           dn_rdata_i,
  input  logic                  dn_error_i
);

  // state | meaning
  // IDLE  | waiting for an upstream request
  // REQ   | downstream access outstanding, timeout counter running
  // RESP  | one-cycle upstream completion pulse
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP} state_t;

  localparam bit       SNAP_ON = (SNAP_EN != 0);
  localparam bit       TO_ON   = (TIMEOUT != 0);
  localparam logic [8:0] TO_LIM = 9'(TIMEOUT);

  state_t state_q, state_d;

  logic                  req_hi_q, req_hi_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  snap_valid_q, snap_valid_d;
  logic [31:0]           snap_hi_q, snap_hi_d;
  logic [ADDR_WIDTH-4:0] snap_addr_q, snap_addr_d;

  logic                  up_ready_d, up_error_d;
  logic [31:0]           up_rdata_d;
  logic                  dn_valid_d, dn_write_d;
  logic [ADDR_WIDTH-1:0] dn_addr_d;
  logic [63:0]           dn_wdata_d;
  logic [7:0]            dn_wstrb_d;

  logic misaligned, snap_hit, timeout_hit;

  assign misaligned  = (up_addr_i[1:0] != 2'b00);
  assign snap_hit    = SNAP_ON && !up_write_i && up_addr_i[2] && snap_valid_q &&
                       (snap_addr_q == up_addr_i[ADDR_WIDTH-1:3]);
  // The count reaches the limit on the cycle being evaluated.
  assign timeout_hit = TO_ON && (({1'b0, cnt_q} + 9'd1) == TO_LIM);

  always_comb begin
    state_d      = state_q;
    req_hi_d     = req_hi_q;
    cnt_d        = cnt_q;
    snap_valid_d = snap_valid_q;
    snap_hi_d    = snap_hi_q;
    snap_addr_d  = snap_addr_q;
    up_ready_d   = 1'b0;
    up_rdata_d   = 32'h0;
    up_error_d   = 1'b0;
    dn_valid_d   = dn_valid_o;
    dn_write_d   = dn_write_o;
    dn_addr_d    = dn_addr_o;
    dn_wdata_d   = dn_wdata_o;
    dn_wstrb_d   = dn_wstrb_o;

    case (state_q)
      ST_IDLE: begin
        if (up_valid_i) begin
          req_hi_d = up_addr_i[2];
          if (up_write_i) snap_valid_d = 1'b0;
          if (misaligned) begin
            state_d    = ST_RESP;
            up_ready_d = 1'b1;
            up_error_d = 1'b1;
          end else if (snap_hit) begin
            state_d      = ST_RESP;
            up_ready_d   = 1'b1;
            up_rdata_d   = snap_hi_q;
            snap_valid_d = 1'b0;
          end else begin
            state_d    = ST_REQ;
            cnt_d      = 8'h0;
            dn_valid_d = 1'b1;
            dn_write_d = up_write_i;
            dn_addr_d  = {up_addr_i[ADDR_WIDTH-1:3], 3'b000};
            dn_wdata_d = {up_wdata_i, up_wdata_i};
            dn_wstrb_d = up_addr_i[2] ? {up_wstrb_i, 4'h0} : {4'h0, up_wstrb_i};
          end
        end
      end
      ST_REQ: begin
        if (dn_ready_i) begin
          state_d    = ST_RESP;
          dn_valid_d = 1'b0;
          up_ready_d = 1'b1;
          up_error_d = dn_error_i;
          if (!dn_write_o) up_rdata_d = req_hi_q ? dn_rdata_i[63:32] : dn_rdata_i[31:0];
          if (SNAP_ON && !dn_write_o && !req_hi_q) begin
            snap_valid_d = !dn_error_i;
            if (!dn_error_i) begin
              snap_hi_d   = dn_rdata_i[63:32];
              snap_addr_d = dn_addr_o[ADDR_WIDTH-1:3];
            end
          end
        end else if (timeout_hit) begin
          state_d      = ST_RESP;
          dn_valid_d   = 1'b0;
          up_ready_d   = 1'b1;
          up_error_d   = 1'b1;
          snap_valid_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      req_hi_q     <= 1'b0;
      cnt_q        <= 8'h0;
      snap_valid_q <= 1'b0;
      snap_hi_q    <= 32'h0;
      snap_addr_q  <= '0;
      up_ready_o   <= 1'b0;
      up_rdata_o   <= 32'h0;
      up_error_o   <= 1'b0;
      dn_valid_o   <= 1'b0;
      dn_write_o   <= 1'b0;
      dn_addr_o    <= '0;
      dn_wdata_o   <= 64'h0;
      dn_wstrb_o   <= 8'h0;
    end else begin
      state_q      <= state_d;
      req_hi_q     <= req_hi_d;
      cnt_q        <= cnt_d;
      snap_valid_q <= snap_valid_d;
      snap_hi_q    <= snap_hi_d;
      snap_addr_q  <= snap_addr_d;
      up_ready_o   <= up_ready_d;
      up_rdata_o   <= up_rdata_d;
      up_error_o   <= up_error_d;
      dn_valid_o   <= dn_valid_d;
      dn_write_o   <= dn_write_d;
      dn_addr_o    <= dn_addr_d;
      dn_wdata_o   <= dn_wdata_d;
      dn_wstrb_o   <= dn_wstrb_d;
    end
  end

endmodule

// File: tb/tb_rv_iommu_reg_widener.sv
// Scoreboard bench for rv_iommu_reg_widener: stimulus queues expected responses,
// independent monitors compare upstream completions and downstream requests.
module tb_rv_iommu_reg_widener;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        up_valid_i, up_write_i;
  logic [31:0] up_addr_i, up_wdata_i;
  logic [3:0]  up_wstrb_i;
  logic        up_ready_o, up_error_o;
  logic [31:0] up_rdata_o;
  logic        dn_valid_o, dn_write_o;
  logic [31:0] dn_addr_o;
  logic [63:0] dn_wdata_o;
  logic [7:0]  dn_wstrb_o;
  logic        dn_ready_i, dn_error_i;
  logic [63:0] dn_rdata_i;

  rv_iommu_reg_widener #(.ADDR_WIDTH(32), .SNAP_EN(1), .TIMEOUT(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .up_valid_i(up_valid_i), .up_write_i(up_write_i), .up_addr_i(up_addr_i),
    .up_wdata_i(up_wdata_i), .up_wstrb_i(up_wstrb_i),
    .up_ready_o(up_ready_o), .up_rdata_o(up_rdata_o), .up_error_o(up_error_o),
    .dn_valid_o(dn_valid_o), .dn_write_o(dn_write_o), .dn_addr_o(dn_addr_o),
    .dn_wdata_o(dn_wdata_o), .dn_wstrb_o(dn_wstrb_o),
    .dn_ready_i(dn_ready_i), .dn_rdata_i(dn_rdata_i), .dn_error_i(dn_error_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [31:0] lat;
  } up_exp_t;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
  } dn_exp_t;

  up_exp_t up_q[$];
  dn_exp_t dn_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int issue_cyc = 0;
  int dn_run = 0;
  int last_run = 0;
  logic dn_prev = 1'b0;

  logic [63:0] model = 64'h0;
  int          resp_delay = 0;
  logic        resp_en = 1'b1;
  logic        resp_err = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: upstream completions and downstream request fields.
  initial begin
    forever begin
      @(posedge clk_i);
      cyc++;
      #1;
      if (up_ready_o) begin
        if (up_q.size() == 0) begin
          chk("up_unexpected_ready", 64'(up_ready_o), 64'h0);
        end else begin
          up_exp_t e;
          e = up_q.pop_front();
          chk("up_rdata", 64'(up_rdata_o), 64'(e.rdata));
          chk("up_error", 64'(up_error_o), 64'(e.err));
          chk("up_latency", 64'(cyc - issue_cyc), 64'(e.lat));
        end
      end
      if (dn_valid_o) begin
        if (!dn_prev) begin
          dn_run = 0;
          if (dn_q.size() == 0) begin
            chk("dn_unexpected_valid", 64'(dn_valid_o), 64'h0);
          end else begin
            dn_exp_t d;
            d = dn_q.pop_front();
            chk("dn_write", 64'(dn_write_o), 64'(d.write));
            chk("dn_addr", 64'(dn_addr_o), 64'(d.addr));
            chk("dn_wdata", dn_wdata_o, d.wdata);
            chk("dn_wstrb", 64'(dn_wstrb_o), 64'(d.wstrb));
          end
        end
        dn_run++;
      end else if (dn_prev) begin
        last_run = dn_run;
      end
      dn_prev = dn_valid_o;
    end
  end

  // Downstream responder: completes after resp_delay waiting cycles.
  initial begin
    int wcnt;
    wcnt = 0;
    dn_ready_i = 1'b0;
    dn_error_i = 1'b0;
    dn_rdata_i = 64'h0;
    forever begin
      @(negedge clk_i);
      dn_ready_i = 1'b0;
      dn_error_i = 1'b0;
      dn_rdata_i = model;
      if (dn_valid_o && resp_en) begin
        if (wcnt == resp_delay) begin
          dn_ready_i = 1'b1;
          dn_error_i = resp_err;
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [31:0] exp_rdata,
                        input logic exp_err, input int exp_lat, input bit goes_dn);
    up_exp_t e;
    dn_exp_t d;
    bit done;
    if (goes_dn) begin
      d.write = wr;
      d.addr  = addr & 32'hFFFF_FFF8;
      d.wdata = {wdata, wdata};
      d.wstrb = addr[2] ? {strb, 4'h0} : {4'h0, strb};
      dn_q.push_back(d);
    end
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.lat   = 32'(exp_lat);
    up_q.push_back(e);
    @(posedge clk_i);
    #1;
    up_valid_i = 1'b1;
    up_write_i = wr;
    up_addr_i  = addr;
    up_wdata_i = wdata;
    up_wstrb_i = strb;
    issue_cyc  = cyc;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk_i);
      #1;
      if (up_ready_o) done = 1'b1;
    end
    if (!done) chk("up_ready_timeout", 64'(done), 64'h1);
    up_valid_i = 1'b0;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_up_ready"}, 64'(up_ready_o), 64'h0);
    chk({tag, "_up_rdata"}, 64'(up_rdata_o), 64'h0);
    chk({tag, "_up_error"}, 64'(up_error_o), 64'h0);
    chk({tag, "_dn_valid"}, 64'(dn_valid_o), 64'h0);
    chk({tag, "_dn_write"}, 64'(dn_write_o), 64'h0);
    chk({tag, "_dn_addr"}, 64'(dn_addr_o), 64'h0);
    chk({tag, "_dn_wdata"}, dn_wdata_o, 64'h0);
    chk({tag, "_dn_wstrb"}, 64'(dn_wstrb_o), 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rst_i = 1'b1;
    up_valid_i = 1'b0;
    up_write_i = 1'b0;
    up_addr_i  = 32'h0;
    up_wdata_i = 32'h0;
    up_wstrb_i = 4'h0;
    repeat (3) @(posedge clk_i);
    #1;
    chk_outputs_zero("reset");
    rst_i = 1'b0;

    // High-word write lands in the upper strobe half.
    access(1'b1, 32'h24, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 2, 1'b1);

    // Snapshot coherence.
    model = 64'h00000001_FFFFFFFF;
    access(1'b0, 32'h58, 32'h0, 4'h0, 32'hFFFFFFFF, 1'b0, 2, 1'b1);
    model = 64'h00000002_00000000;
    access(1'b0, 32'h5C, 32'h0, 4'h0, 32'h00000001, 1'b0, 1, 1'b0);
    access(1'b0, 32'h5C, 32'h0, 4'h0, 32'h00000002, 1'b0, 2, 1'b1);

    // A write anywhere invalidates the snapshot.
    access(1'b0, 32'h58, 32'h0, 4'h0, 32'h00000000, 1'b0, 2, 1'b1);
    access(1'b1, 32'h100, 32'h12345678, 4'h3, 32'h0, 1'b0, 2, 1'b1);
    model = 64'h00000003_00000000;
    access(1'b0, 32'h5C, 32'h0, 4'h0, 32'h00000003, 1'b0, 2, 1'b1);

    // Misaligned read.
    access(1'b0, 32'h22, 32'h0, 4'h0, 32'h0, 1'b1, 1, 1'b0);

    // Ready arriving on the timeout-limit cycle completes normally.
    model = 64'hAAAA5555_CAFEF00D;
    resp_delay = 3;
    access(1'b0, 32'h44, 32'h0, 4'h0, 32'hAAAA5555, 1'b0, 5, 1'b1);
    resp_delay = 0;
    access(1'b0, 32'h40, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, 2, 1'b1);
    model = 64'h77778888_00000000;
    access(1'b0, 32'h44, 32'h0, 4'h0, 32'hAAAA5555, 1'b0, 1, 1'b0);

    // Errored low read clears the snapshot.
    model = 64'hAAAA5555_CAFEF00D;
    access(1'b0, 32'h40, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, 2, 1'b1);
    model = 64'h0;
    resp_err = 1'b1;
    access(1'b0, 32'h40, 32'h0, 4'h0, 32'h0, 1'b1, 2, 1'b1);
    resp_err = 1'b0;
    model = 64'h11112222_33334444;
    access(1'b0, 32'h44, 32'h0, 4'h0, 32'h11112222, 1'b0, 2, 1'b1);

    // Timeout aborts, clears the snapshot, and the next access is normal.
    model = 64'h55556666_77778888;
    access(1'b0, 32'h88, 32'h0, 4'h0, 32'h77778888, 1'b0, 2, 1'b1);
    resp_en = 1'b0;
    access(1'b0, 32'h90, 32'h0, 4'h0, 32'h0, 1'b1, 5, 1'b1);
    @(negedge clk_i);
    chk("timeout_dn_valid_cycles", 64'(last_run), 64'd4);
    resp_en = 1'b1;
    access(1'b0, 32'h8C, 32'h0, 4'h0, 32'h55556666, 1'b0, 2, 1'b1);

    // Reset while a downstream request is outstanding.
    model = 64'h9999AAAA_BBBBCCCC;
    access(1'b0, 32'h38, 32'h0, 4'h0, 32'hBBBBCCCC, 1'b0, 2, 1'b1);
    resp_en = 1'b0;
    begin
      dn_exp_t d;
      d.write = 1'b0;
      d.addr  = 32'h30;
      d.wdata = 64'h0;
      d.wstrb = 8'h0;
      dn_q.push_back(d);
    end
    @(posedge clk_i);
    #1;
    up_valid_i = 1'b1;
    up_write_i = 1'b0;
    up_addr_i  = 32'h30;
    up_wdata_i = 32'h0;
    up_wstrb_i = 4'h0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk_i);
      #1;
      if (dn_valid_o) seen = 1'b1;
    end
    chk("reset_mid_req_dn_valid_seen", 64'(seen), 64'h1);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    #1;
    chk_outputs_zero("mid_req_reset");
    up_valid_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    resp_en = 1'b1;
    access(1'b0, 32'h3C, 32'h0, 4'h0, 32'h9999AAAA, 1'b0, 2, 1'b1);

    repeat (3) @(posedge clk_i);
    #1;
    chk("up_queue_drained", 64'(up_q.size()), 64'h0);
    chk("dn_queue_drained", 64'(dn_q.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
